// File: rtl/input_selector.sv
// rtl/input_selector.sv - bit-addressable input port with per-pin synchronisers, sticky edge flags and irq
module input_selector #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pins,
    input  logic       CE,
    input  logic       read,
    input  logic       clearEdge,
    input  logic [2:0] addr,
    output logic       data,
    output logic       dataValid,
    output logic [7:0] edgeFlags,
    output logic       irq
);

    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_out;
    logic [7:0] prev;
    logic [7:0] detect;
    logic [7:0] next_flags;
    logic [2:0] arm_cnt;
    logic       armed;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_cnt == ARM_MAX);

    // Clear is applied first so a coincident detect on the same bit wins.
    always_comb begin
        if (EDGE_MODE == 0) begin
            detect = sync_out & ~prev;
        end else if (EDGE_MODE == 1) begin
            detect = ~sync_out & prev;
        end else begin
            detect = sync_out ^ prev;
        end
        next_flags = edgeFlags;
        if (CE && clearEdge) begin
            next_flags[addr] = 1'b0;
        end
        if (armed) begin
            next_flags = next_flags | detect;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h00;
            end
            prev      <= 8'h00;
            arm_cnt   <= 3'd0;
            edgeFlags <= 8'h00;
            irq       <= 1'b0;
            data      <= 1'b0;
            dataValid <= 1'b0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= sync_out;
            // Masks detection until the synchronisers hold post-reset pin levels.
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
            edgeFlags <= next_flags;
            irq       <= |next_flags;
            dataValid <= CE && read;
            if (CE && read) begin
                data <= sync_out[addr];
            end
        end
    end

endmodule
